system_worker2_cpu_ocm_arbiter: RTL and testbench

//  Two-port Avalon-MM arbiter that shares worker2's single-port CPU OCM (128 x 32, byte-enabled).
//  The OCM has registered address, unregistered q, and 1-cycle read latency.

---
 rtl/system_ocm_arb_pkg.sv | 22 ++
 rtl/system_worker2_cpu_ocm_arbiter_if.sv | 29 ++
 rtl/system_ocm_arb_pick.sv | 48 ++++
 rtl/system_worker2_cpu_ocm_arbiter.sv | 108 ++++++++++
 tb/tb_system_worker2_cpu_ocm_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/system_ocm_arb_pkg.sv
// Shared types and default widths for the worker2 CPU OCM arbiter.
package system_ocm_arb_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_BE_W   = DEF_DATA_W / 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Port id: 0 = m0, 1 = m1.
    typedef logic port_t;

    function automatic state_t own_state(input port_t p);
        return p ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/system_worker2_cpu_ocm_arbiter_if.sv
// Avalon-MM master port bundle; one instance per arbiter master.
interface system_worker2_cpu_ocm_arbiter_if
    import system_ocm_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W   = DEF_BE_W
);

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/system_ocm_arb_pick.sv
// Combinational grant decision: round robin from IDLE, owner kept until its
// burst budget runs out while the other port is waiting.
module system_ocm_arb_pick
    import system_ocm_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  state_t           state,
    input  logic [CNT_W-1:0] burst_cnt,
    input  logic             req0,
    input  logic             req1,
    input  port_t            rr_last,
    input  logic             reset_req,
    output logic             gnt0,
    output logic             gnt1
);

    port_t own;
    logic  own_req;
    logic  oth_req;

    // Pick at most one port per cycle; nothing while blocked.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        own     = (state == OWN1);
        own_req = own ? req1 : req0;
        oth_req = own ? req0 : req1;
        if (!reset_req) begin
            if (state == IDLE) begin
                if (req0 && req1) begin
                    gnt0 = rr_last;
                    gnt1 = ~rr_last;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end else if (own_req && ((burst_cnt < CNT_W'(MAX_BURST)) || !oth_req)) begin
                gnt0 = ~own;
                gnt1 = own;
            end else if (oth_req) begin
                gnt0 = own;
                gnt1 = ~own;
            end
        end
    end

endmodule

// File: rtl/system_worker2_cpu_ocm_arbiter.sv
// Two-master arbiter in front of worker2's single-port CPU OCM.
// Holds ownership/burst state, muxes the granted request onto the OCM pins
// and routes the 1-cycle read response back to the issuing port.
module system_worker2_cpu_ocm_arbiter
    import system_ocm_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BE_W      = DEF_BE_W,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       reset_req,
    system_worker2_cpu_ocm_arbiter_if.slave m0,
    system_worker2_cpu_ocm_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]          ram_address,
    output logic [BE_W-1:0]            ram_byteenable,
    output logic                       ram_chipselect,
    output logic                       ram_write,
    output logic [DATA_W-1:0]          ram_writedata,
    output logic                       ram_clken,
    input  logic [DATA_W-1:0]          ram_readdata
);

    state_t           state, state_n;
    logic [CNT_W-1:0] burst_cnt, cnt_n;
    port_t            rr_last, rr_n;
    logic             rsp_valid;
    port_t            rsp_port;
    logic             req0, req1, gnt0, gnt1, block, rd_acc;
    port_t            gnt_port;

    assign req0     = m0.read | m0.write;
    assign req1     = m1.read | m1.write;
    assign block    = reset_req | ~reset_n;
    assign gnt_port = gnt1;

    system_ocm_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
        .state     (state),
        .burst_cnt (burst_cnt),
        .req0      (req0),
        .req1      (req1),
        .rr_last   (rr_last),
        .reset_req (block),
        .gnt0      (gnt0),
        .gnt1      (gnt1)
    );

    // Request mux onto the OCM; write wins when read and write are both set.
    always_comb begin
        ram_address    = gnt1 ? m1.address    : m0.address;
        ram_byteenable = gnt1 ? m1.byteenable : m0.byteenable;
        ram_writedata  = gnt1 ? m1.writedata  : m0.writedata;
        ram_chipselect = gnt0 | gnt1;
        ram_write      = (gnt0 & m0.write) | (gnt1 & m1.write);
        rd_acc         = (gnt0 & m0.read & ~m0.write) | (gnt1 & m1.read & ~m1.write);
    end

    assign ram_clken        = ~reset_req;
    assign m0.waitrequest   = ~gnt0;
    assign m1.waitrequest   = ~gnt1;
    assign m0.readdata      = ram_readdata;
    assign m1.readdata      = ram_readdata;
    assign m0.readdatavalid = rsp_valid & ~rsp_port;
    assign m1.readdatavalid = rsp_valid & rsp_port;

    // Next ownership: continuing owner bumps a saturating run count, a new owner restarts it.
    always_comb begin
        state_n = IDLE;
        cnt_n   = '0;
        rr_n    = rr_last;
        if (gnt0 || gnt1) begin
            state_n = own_state(gnt_port);
            if (state == own_state(gnt_port)) begin
                cnt_n = (burst_cnt < CNT_W'(MAX_BURST)) ? burst_cnt + 1'b1 : burst_cnt;
            end else begin
                cnt_n = CNT_W'(1);
                rr_n  = gnt_port;
            end
        end
    end

    // Ownership registers; rr_last resets to 1 so m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
            rr_last   <= 1'b1;
        end else begin
            state     <= state_n;
            burst_cnt <= cnt_n;
            rr_last   <= rr_n;
        end
    end

    // Read response tag; OCM q appears one cycle after the accepted read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_port  <= 1'b0;
        end else begin
            rsp_valid <= rd_acc;
            rsp_port  <= gnt_port;
        end
    end

endmodule

// File: tb/tb_system_worker2_cpu_ocm_arbiter.sv
// Bench for the worker2 CPU OCM arbiter: directed scenarios plus a random
// run against a transaction-level model of the arbitration rules.
module tb_system_worker2_cpu_ocm_arbiter;
    localparam int AW = 7, DW = 32, BW = 4, MAXB = 4;

    logic          clk = 1'b0;
    logic          reset_n, reset_req;
    logic [AW-1:0] ram_address;
    logic [BW-1:0] ram_byteenable;
    logic          ram_chipselect, ram_write, ram_clken;
    logic [DW-1:0] ram_writedata, ram_readdata;

    system_worker2_cpu_ocm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m0_if ();
    system_worker2_cpu_ocm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m1_if ();

    system_worker2_cpu_ocm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset_n(reset_n), .reset_req(reset_req), .m0(m0_if), .m1(m1_if),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata)
    );

    always #5 clk = ~clk;

    // OCM model: registered address, unregistered q, byte-enabled writes.
    logic [DW-1:0] mem [0:127];
    logic [AW-1:0] ram_areg;
    always @(posedge clk) begin
        if (ram_clken) begin
            if (ram_chipselect && ram_write)
                for (int b = 0; b < BW; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            ram_areg <= ram_address;
        end
    end
    assign ram_readdata = mem[ram_areg];

    logic [DW-1:0] shadow [0:127];
    int total = 0, bad = 0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic set_port(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [BW-1:0] be, input logic [DW-1:0] d);
        if (p == 0) begin
            m0_if.read = rd; m0_if.write = wr; m0_if.address = a; m0_if.byteenable = be; m0_if.writedata = d;
        end else begin
            m1_if.read = rd; m1_if.write = wr; m1_if.address = a; m1_if.byteenable = be; m1_if.writedata = d;
        end
    endtask

    task automatic idle_all();
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk); reset_n = 1'b0; reset_req = 1'b0; idle_all();
        @(negedge clk);
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0; reset_req = 1'b0; idle_all();
        set_port(0, 1'b1, 1'b0, 7'h05, 4'hF, '0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (m0_if.waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wait0: got %b want 1", m0_if.waitrequest); end
            total++; if (ram_chipselect !== 1'b0) begin bad++; $display("FAIL rst_cs: got %b want 0", ram_chipselect); end
            total++; if ({m1_if.readdatavalid, m0_if.readdatavalid} !== 2'b00) begin bad++; $display("FAIL rst_rdv: got %b%b want 00", m1_if.readdatavalid, m0_if.readdatavalid); end
            @(negedge clk);
        end
        reset_n = 1'b1; #1;
        total++; if (m0_if.waitrequest !== 1'b0) begin bad++; $display("FAIL rst_first_gnt: wait0 got %b want 0", m0_if.waitrequest); end
        total++; if (ram_chipselect !== 1'b1) begin bad++; $display("FAIL rst_first_cs: got %b want 1", ram_chipselect); end
        @(negedge clk); idle_all(); #1;
        total++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== shadow[5]) begin bad++; $display("FAIL rst_first_rd: rdv %b data %h want 1 %h", m0_if.readdatavalid, m0_if.readdata, shadow[5]); end
    endtask

    task automatic write_then_read(input string nm, input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
        logic [DW-1:0] exp;
        do_reset();
        set_port(0, 1'b0, 1'b1, a, be, d); #1;
        total++; if (m0_if.waitrequest !== 1'b0 || ram_write !== 1'b1) begin bad++; $display("FAIL %s_wr_acc: wait %b ramwr %b want 0 1", nm, m0_if.waitrequest, ram_write); end
        total++; if (ram_address !== a || ram_byteenable !== be || ram_writedata !== d) begin bad++; $display("FAIL %s_wr_bus: a %h be %h d %h want %h %h %h", nm, ram_address, ram_byteenable, ram_writedata, a, be, d); end
        shadow[a] = merge(shadow[a], d, be);
        exp = shadow[a];
        @(negedge clk); set_port(0, 1'b1, 1'b0, a, 4'hF, '0); #1;
        total++; if (m0_if.waitrequest !== 1'b0 || ram_write !== 1'b0) begin bad++; $display("FAIL %s_rd_acc: wait %b ramwr %b want 0 0", nm, m0_if.waitrequest, ram_write); end
        total++; if (m0_if.readdatavalid !== 1'b0) begin bad++; $display("FAIL %s_wr_nordv: got %b want 0", nm, m0_if.readdatavalid); end
        @(negedge clk); idle_all(); #1;
        total++; if (m0_if.readdatavalid !== 1'b1 || m1_if.readdatavalid !== 1'b0) begin bad++; $display("FAIL %s_rdv: got %b%b want 01", nm, m1_if.readdatavalid, m0_if.readdatavalid); end
        total++; if (m0_if.readdata !== exp) begin bad++; $display("FAIL %s_data: got %h want %h", nm, m0_if.readdata, exp); end
        @(negedge clk); #1;
        total++; if (m0_if.readdatavalid !== 1'b0) begin bad++; $display("FAIL %s_rdv_once: got %b want 0", nm, m0_if.readdatavalid); end
    endtask

    task automatic test_write_read();
        write_then_read("wrrd", 7'h05, 4'hF, 32'hDEADBEEF);
    endtask

    task automatic test_byte_write();
        write_then_read("bytewr", 7'h05, 4'h2, 32'h0000AA00);
        total++; if (shadow[5] !== 32'hDEADAAEF) begin bad++; $display("FAIL bytewr_merge: got %h want deadaaef", shadow[5]); end
    endtask

    task automatic test_burst_sat();
        logic [DW-1:0] d, exp;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            d = $urandom;
            set_port(0, 1'b0, 1'b1, AW'(i), 4'hF, d); #1;
            total++; if (m0_if.waitrequest !== 1'b0) begin bad++; $display("FAIL sat_hold[%0d]: wait0 got %b want 0", i, m0_if.waitrequest); end
            shadow[i] = d;
            @(negedge clk);
        end
        d = $urandom;
        set_port(0, 1'b0, 1'b1, 7'd32, 4'hF, d);
        set_port(1, 1'b1, 1'b0, 7'd3, 4'hF, '0); #1;
        total++; if ({m1_if.waitrequest, m0_if.waitrequest} !== 2'b01) begin bad++; $display("FAIL sat_yield: wait10 got %b%b want 01", m1_if.waitrequest, m0_if.waitrequest); end
        exp = shadow[3];
        @(negedge clk); set_port(1, 1'b0, 1'b0, '0, '0, '0); #1;
        total++; if (m0_if.waitrequest !== 1'b0) begin bad++; $display("FAIL sat_back: wait0 got %b want 0", m0_if.waitrequest); end
        total++; if (m1_if.readdatavalid !== 1'b1 || m0_if.readdatavalid !== 1'b0 || m1_if.readdata !== exp) begin bad++; $display("FAIL sat_rsp: rdv %b%b data %h want 10 %h", m1_if.readdatavalid, m0_if.readdatavalid, m1_if.readdata, exp); end
        shadow[32] = d;
        @(negedge clk); idle_all();
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] a0, a1, pa;
        int want, prev;
        do_reset();
        a0 = 7'd0; a1 = 7'd16; prev = -1; pa = '0;
        set_port(0, 1'b1, 1'b0, a0, 4'hF, '0);
        set_port(1, 1'b1, 1'b0, a1, 4'hF, '0);
        for (int i = 0; i < 16; i++) begin
            #1;
            want = ((i / MAXB) % 2 == 0) ? 0 : 1;
            total++; if (m0_if.waitrequest !== (want != 0) || m1_if.waitrequest !== (want != 1)) begin bad++; $display("FAIL rr_gnt[%0d]: wait10 %b%b want port %0d", i, m1_if.waitrequest, m0_if.waitrequest, want); end
            if (prev >= 0) begin
                total++; if (m0_if.readdatavalid !== (prev == 0) || m1_if.readdatavalid !== (prev == 1) || m0_if.readdata !== shadow[pa]) begin bad++; $display("FAIL rr_rsp[%0d]: rdv10 %b%b data %h want port %0d %h", i, m1_if.readdatavalid, m0_if.readdatavalid, m0_if.readdata, prev, shadow[pa]); end
            end
            prev = want; pa = (want == 0) ? a0 : a1;
            @(negedge clk);
            if (want == 0) begin a0 = a0 + 1'b1; set_port(0, 1'b1, 1'b0, a0, 4'hF, '0); end
            else begin a1 = a1 + 1'b1; set_port(1, 1'b1, 1'b0, a1, 4'hF, '0); end
        end
        idle_all(); #1;
        total++; if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== shadow[pa]) begin bad++; $display("FAIL rr_last_rsp: rdv1 %b data %h want 1 %h", m1_if.readdatavalid, m1_if.readdata, shadow[pa]); end
    endtask

    task automatic test_tie();
        do_reset();
        set_port(0, 1'b1, 1'b0, 7'd1, 4'hF, '0);
        set_port(1, 1'b1, 1'b0, 7'd2, 4'hF, '0); #1;
        total++; if ({m1_if.waitrequest, m0_if.waitrequest} !== 2'b10) begin bad++; $display("FAIL tie_first: wait10 %b%b want 10", m1_if.waitrequest, m0_if.waitrequest); end
        @(negedge clk); set_port(0, 1'b0, 1'b0, '0, '0, '0); #1;
        total++; if (m1_if.waitrequest !== 1'b0 || ram_address !== 7'd2) begin bad++; $display("FAIL tie_switch: wait1 %b addr %h want 0 02", m1_if.waitrequest, ram_address); end
        @(negedge clk); idle_all();
        @(negedge clk); set_port(0, 1'b1, 1'b0, 7'd4, 4'hF, '0); #1;
        total++; if (m0_if.waitrequest !== 1'b0) begin bad++; $display("FAIL tie_solo0: wait0 %b want 0", m0_if.waitrequest); end
        @(negedge clk); idle_all();
        @(negedge clk);
        set_port(0, 1'b1, 1'b0, 7'd1, 4'hF, '0);
        set_port(1, 1'b1, 1'b0, 7'd2, 4'hF, '0); #1;
        total++; if ({m1_if.waitrequest, m0_if.waitrequest} !== 2'b01) begin bad++; $display("FAIL tie_second: wait10 %b%b want 01", m1_if.waitrequest, m0_if.waitrequest); end
        @(negedge clk); set_port(1, 1'b0, 1'b0, '0, '0, '0); #1;
        total++; if (m0_if.waitrequest !== 1'b0) begin bad++; $display("FAIL tie_second_switch: wait0 %b want 0", m0_if.waitrequest); end
        @(negedge clk); idle_all();
    endtask

    task automatic test_reset_req();
        logic [DW-1:0] exp;
        do_reset();
        set_port(0, 1'b0, 1'b1, 7'd9, 4'hF, 32'h5A5A1234); #1;
        shadow[9] = 32'h5A5A1234;
        exp = shadow[9];
        @(negedge clk); set_port(0, 1'b1, 1'b0, 7'd9, 4'hF, '0); #1;
        total++; if (m0_if.waitrequest !== 1'b0) begin bad++; $display("FAIL rreq_acc: wait0 %b want 0", m0_if.waitrequest); end
        @(negedge clk);
        reset_req = 1'b1;
        set_port(1, 1'b1, 1'b0, 7'd3, 4'hF, '0); #1;
        total++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== exp) begin bad++; $display("FAIL rreq_rsp: rdv0 %b data %h want 1 %h", m0_if.readdatavalid, m0_if.readdata, exp); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            total++; if ({m1_if.waitrequest, m0_if.waitrequest, ram_chipselect, ram_clken} !== 4'b1100) begin bad++; $display("FAIL rreq_block[%0d]: w1 w0 cs clken %b%b%b%b want 1100", i, m1_if.waitrequest, m0_if.waitrequest, ram_chipselect, ram_clken); end
        end
        @(negedge clk); reset_req = 1'b0; #1;
        total++; if (ram_clken !== 1'b1) begin bad++; $display("FAIL rreq_clken: got %b want 1", ram_clken); end
        total++; if ({m1_if.waitrequest, m0_if.waitrequest} !== 2'b01) begin bad++; $display("FAIL rreq_resume: wait10 %b%b want 01", m1_if.waitrequest, m0_if.waitrequest); end
        @(negedge clk); idle_all();
    endtask

    // Model state: pending request per port, last granted port, previous-cycle
    // grant and length of the current uninterrupted run of grants.
    logic          p_pend [2];
    logic          p_rd [2];
    logic          p_wr [2];
    logic [AW-1:0] p_a [2];
    logic [BW-1:0] p_be [2];
    logic [DW-1:0] p_d [2];

    task automatic test_random();
        int last_port, prev_g, run, g, own, oth, rsp_p, kind;
        logic [DW-1:0] rsp_d;
        do_reset();
        last_port = 1; prev_g = -1; run = 0; rsp_p = -1; rsp_d = '0;
        p_pend[0] = 1'b0; p_pend[1] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_pend[p] && $urandom_range(0, 3) != 0) begin
                    kind = $urandom_range(0, 3);
                    p_pend[p] = 1'b1;
                    p_rd[p] = (kind != 2);
                    p_wr[p] = (kind >= 2);
                    p_a[p] = AW'($urandom_range(0, 127));
                    p_be[p] = BW'($urandom_range(1, 15));
                    p_d[p] = $urandom;
                end
                set_port(p, p_pend[p] & p_rd[p], p_pend[p] & p_wr[p], p_a[p], p_be[p], p_d[p]);
            end
            reset_req = ($urandom_range(0, 15) == 0);
            #1;
            g = -1;
            if (!reset_req) begin
                if (prev_g < 0) begin
                    if (p_pend[0] && p_pend[1]) g = 1 - last_port;
                    else if (p_pend[0]) g = 0;
                    else if (p_pend[1]) g = 1;
                end else begin
                    own = prev_g; oth = 1 - prev_g;
                    if (p_pend[own] && (run < MAXB || !p_pend[oth])) g = own;
                    else if (p_pend[oth]) g = oth;
                end
            end
            total++; if (m0_if.waitrequest !== (g != 0) || m1_if.waitrequest !== (g != 1) || ram_chipselect !== (g >= 0)) begin bad++; $display("FAIL rnd_gnt[%0d]: w1 w0 cs %b%b%b want grant %0d", cyc, m1_if.waitrequest, m0_if.waitrequest, ram_chipselect, g); end
            total++; if (ram_clken !== ~reset_req) begin bad++; $display("FAIL rnd_clken[%0d]: got %b want %b", cyc, ram_clken, ~reset_req); end
            if (g >= 0) begin
                total++; if (ram_address !== p_a[g] || ram_write !== p_wr[g]) begin bad++; $display("FAIL rnd_bus[%0d]: addr %h wr %b want %h %b", cyc, ram_address, ram_write, p_a[g], p_wr[g]); end
            end
            total++; if (m0_if.readdatavalid !== (rsp_p == 0) || m1_if.readdatavalid !== (rsp_p == 1)) begin bad++; $display("FAIL rnd_rdv[%0d]: rdv10 %b%b want port %0d", cyc, m1_if.readdatavalid, m0_if.readdatavalid, rsp_p); end
            if (rsp_p >= 0) begin
                total++; if (m0_if.readdata !== rsp_d) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", cyc, m0_if.readdata, rsp_d); end
            end
            rsp_p = -1;
            if (g >= 0) begin
                if (p_wr[g]) shadow[p_a[g]] = merge(shadow[p_a[g]], p_d[g], p_be[g]);
                else begin rsp_p = g; rsp_d = shadow[p_a[g]]; end
                if (g == prev_g) run = (run < MAXB) ? run + 1 : run;
                else begin run = 1; last_port = g; end
                p_pend[g] = 1'b0;
            end else begin
                run = 0;
            end
            prev_g = g;
            @(negedge clk);
        end
        reset_req = 1'b0; idle_all();
    endtask

    initial begin
        reset_n = 1'b0; reset_req = 1'b0; idle_all();
        for (int i = 0; i < 128; i++) begin mem[i] = '0; shadow[i] = '0; end
        ram_areg = '0;
        test_reset();
        test_write_read();
        test_byte_write();
        test_burst_sat();
        test_round_robin();
        test_tie();
        test_reset_req();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, want bench finished");
        $fatal(1, "watchdog");
    end

endmodule
